// File: rtl/cotm32_pkg.sv
// cotm32_pkg: shared types for the load/store unit
package cotm32_pkg;
  localparam int XLEN = 32;
  typedef enum logic [3:0] {
    LB  = 4'b0000,
    LH  = 4'b0001,
    LW  = 4'b0010,
    LBU = 4'b0100,
    LHU = 4'b0101,
    SB  = 4'b1000,
    SH  = 4'b1001,
    SW  = 4'b1010
  } lsu_op_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: misalignment check, byte enables, store replication and load extension
module lsu_align
  import cotm32_pkg::*;
(
  input  lsu_op_t         i_op,
  input  logic [1:0]      i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic            o_misalign,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata
);
  logic [1:0]      w_size;
  logic            w_uns;
  logic [XLEN-1:0] w_sh;
  always_comb begin
    w_size     = i_op[1:0];
    w_uns      = i_op[2];
    w_sh       = i_rdata >> {i_addr, 3'b000};
    o_misalign = (w_size == 2'b01 && i_addr[0]) || (w_size[1] && i_addr != 2'b00);
    o_be       = w_size == 2'b00 ? 4'b0001 << i_addr :
                 w_size == 2'b01 ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    o_wdata    = w_size == 2'b00 ? {4{i_wdata[7:0]}} :
                 w_size == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
    o_rdata    = i_op[3] ? '0 :
                 w_size == 2'b00 ? {{(XLEN-8){~w_uns & w_sh[7]}}, w_sh[7:0]} :
                 w_size == 2'b01 ? {{(XLEN-16){~w_uns & w_sh[15]}}, w_sh[15:0]} : w_sh;
  end
endmodule

// File: rtl/lsu.sv
// lsu: memory-stage load/store unit driving one valid/ready bus transfer per request
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module lsu
  import cotm32_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req,
  input  lsu_op_t         i_op,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_fault_misalign,
  output logic            o_fault_bus,
  output logic            o_bus_valid,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [XLEN-1:0] o_bus_wdata,
  output logic [3:0]      o_bus_be,
  input  logic            i_bus_ready,
  input  logic [XLEN-1:0] i_bus_rdata,
  input  logic            i_bus_err
);
  lsu_state_t      r_state, w_next;
  lsu_op_t         r_op, w_op;
  logic [XLEN-1:0] r_addr, r_bwdata, r_rdata, w_wrep, w_ext;
  logic [3:0]      r_be, w_be;
  logic [1:0]      w_lane;
  logic            r_fmis, r_fbus, w_mis, w_accept, w_timeout, w_in_bus;
  assign w_in_bus = r_state == S_BUS;
  assign w_accept = i_req && !w_in_bus;
  // One aligner serves both the incoming request and the in-flight response.
  assign w_op     = w_in_bus ? r_op : i_op;
  assign w_lane   = w_in_bus ? r_addr[1:0] : i_addr[1:0];
  lsu_align u_align (
    .i_op      (w_op),
    .i_addr    (w_lane),
    .i_wdata   (i_wdata),
    .i_rdata   (i_bus_rdata),
    .o_misalign(w_mis),
    .o_be      (w_be),
    .o_wdata   (w_wrep),
    .o_rdata   (w_ext)
  );
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  assign w_timeout = w_in_bus && !i_bus_ready && r_cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge i_clk) begin
    if (i_rst || w_accept) r_cnt <= '0;
    else if (w_in_bus) r_cnt <= r_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_next = S_IDLE;
    if (w_accept) w_next = w_mis ? S_RESP : S_BUS;
    else if (w_in_bus) w_next = (i_bus_ready || w_timeout) ? S_RESP : S_BUS;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= LB;
      r_addr   <= '0;
      r_be     <= '0;
      r_bwdata <= '0;
      r_rdata  <= '0;
      r_fmis   <= 1'b0;
      r_fbus   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op     <= i_op;
        r_addr   <= i_addr;
        r_be     <= w_be;
        r_bwdata <= w_wrep;
        r_rdata  <= '0;
        r_fmis   <= w_mis;
        r_fbus   <= 1'b0;
      end else if (w_in_bus) begin
        r_rdata <= (i_bus_ready && !i_bus_err) ? w_ext : '0;
        r_fmis  <= 1'b0;
        r_fbus  <= i_bus_ready ? i_bus_err : w_timeout;
      end
    end
  end
  assign o_busy           = w_in_bus;
  assign o_done           = r_state == S_RESP;
  assign o_rdata          = o_done ? r_rdata : '0;
  assign o_fault_misalign = o_done & r_fmis;
  assign o_fault_bus      = o_done & r_fbus;
  assign o_bus_valid      = w_in_bus;
  assign o_bus_we         = w_in_bus & r_op[3];
  assign o_bus_addr       = w_in_bus ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign o_bus_wdata      = w_in_bus ? r_bwdata : '0;
  assign o_bus_be         = w_in_bus ? r_be : 4'b0000;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu
module tb_lsu;
  import cotm32_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, req = 1'b0;
  lsu_op_t     op = LB;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0, rdata, bus_addr, bus_wdata;
  logic        busy, done, fmis, fbus, bus_valid, bus_we, bus_ready = 1'b0, bus_err = 1'b0;
  logic [3:0]  bus_be;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
`ifdef LSU_TIMEOUT_EN
  lsu #(.TIMEOUT_CYCLES(4)) dut (
`else
  lsu dut (
`endif
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_rdata(rdata), .o_fault_misalign(fmis), .o_fault_bus(fbus),
    .o_bus_valid(bus_valid), .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
    .o_bus_be(bus_be), .i_bus_ready(bus_ready), .i_bus_rdata(bus_rdata), .i_bus_err(bus_err));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Pulse a request for one cycle; returns at the negedge after it was sampled.
  task automatic start(input lsu_op_t o, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
  endtask
  // Called in the first BUS cycle; returns at the negedge of the done cycle.
  task automatic ack(input int waits, input logic [31:0] rd, input logic err);
    for (int i = 0; i < waits; i++) begin
      check("valid_wait", {31'b0, bus_valid}, 32'd1);
      @(negedge clk);
    end
    check("valid_ack", {31'b0, bus_valid}, 32'd1);
    bus_ready = 1'b1; bus_rdata = rd; bus_err = err;
    @(negedge clk);
    bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_valid", {31'b0, bus_valid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    start(SW, 32'h100, 32'hDEADBEEF);
    check("sw_busy", {31'b0, busy}, 32'd1);
    check("sw_addr", bus_addr, 32'h100);
    check("sw_be", {28'b0, bus_be}, 32'hF);
    check("sw_we", {31'b0, bus_we}, 32'd1);
    check("sw_wdata", bus_wdata, 32'hDEADBEEF);
    ack(2, 32'h0, 1'b0);
    check("sw_done", {31'b0, done}, 32'd1);
    check("sw_faults", {30'b0, fmis, fbus}, 32'd0);
    check("sw_valid_off", {31'b0, bus_valid}, 32'd0);
    @(negedge clk);
    check("sw_done_1cyc", {31'b0, done}, 32'd0);
    start(LB, 32'h203, 32'h0);
    check("lb_be", {28'b0, bus_be}, 32'h8);
    check("lb_we", {31'b0, bus_we}, 32'd0);
    check("lb_addr", bus_addr, 32'h200);
    ack(0, 32'h80FF7F01, 1'b0);
    check("lb_rdata", rdata, 32'hFFFFFF80);
    start(LBU, 32'h203, 32'h0);
    ack(0, 32'h80FF7F01, 1'b0);
    check("lbu_rdata", rdata, 32'h00000080);
    start(LH, 32'h202, 32'h0);
    check("lh_be", {28'b0, bus_be}, 32'hC);
    ack(0, 32'h9234ABCD, 1'b0);
    check("lh_rdata", rdata, 32'hFFFF9234);
    start(LHU, 32'h200, 32'h0);
    check("lhu_be", {28'b0, bus_be}, 32'h3);
    ack(0, 32'h9234ABCD, 1'b0);
    check("lhu_rdata", rdata, 32'h0000ABCD);
    start(SH, 32'h301, 32'h1234);
    check("sh_mis_done", {31'b0, done}, 32'd1);
    check("sh_mis_flag", {31'b0, fmis}, 32'd1);
    check("sh_mis_valid", {31'b0, bus_valid}, 32'd0);
    start(LW, 32'h302, 32'h0);
    check("lw_mis_done", {31'b0, done}, 32'd1);
    check("lw_mis_flag", {31'b0, fmis}, 32'd1);
    check("lw_mis_valid", {31'b0, bus_valid}, 32'd0);
    check("lw_mis_rdata", rdata, 32'd0);
    start(LW, 32'h400, 32'h0);
    ack(1, 32'h12345678, 1'b1);
    check("err_done", {31'b0, done}, 32'd1);
    check("err_fbus", {31'b0, fbus}, 32'd1);
    check("err_fmis", {31'b0, fmis}, 32'd0);
    check("err_rdata", rdata, 32'd0);
    start(SB, 32'h13, 32'hAB);
    check("sb_wdata", bus_wdata, 32'hABABABAB);
    check("sb_be", {28'b0, bus_be}, 32'h8);
    check("sb_addr", bus_addr, 32'h10);
    ack(0, 32'h0, 1'b0);
    check("sb_done", {31'b0, done}, 32'd1);
    start(LW, 32'h500, 32'h0);
    req = 1'b1; op = SW; addr = 32'h600;
    @(negedge clk);
    req = 1'b0;
    check("ign_addr", bus_addr, 32'h500);
    check("ign_we", {31'b0, bus_we}, 32'd0);
    ack(0, 32'hCAFEF00D, 1'b0);
    check("b2b_rdata", rdata, 32'hCAFEF00D);
    req = 1'b1; op = LHU; addr = 32'h502;
    @(negedge clk);
    req = 1'b0;
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check("b2b_be", {28'b0, bus_be}, 32'hC);
    ack(0, 32'h12345678, 1'b0);
    check("b2b_rdata2", rdata, 32'h00001234);
    @(negedge clk);
    check("b2b_no_extra", {31'b0, done}, 32'd0);
    start(SW, 32'h700, 32'h55);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_valid", {31'b0, bus_valid}, 32'd0);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("mrst_done2", {31'b0, done}, 32'd0);
`ifdef LSU_TIMEOUT_EN
    begin
      int n = 0;
      start(LW, 32'h800, 32'h0);
      while (bus_valid && n < 10) begin
        n++;
        @(negedge clk);
      end
      check("to_cycles", n, 32'd4);
      check("to_done", {31'b0, done}, 32'd1);
      check("to_fbus", {31'b0, fbus}, 32'd1);
      check("to_rdata", rdata, 32'd0);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
